// File: rtl/wave_scaler_pkg.sv
// Shared definitions for the wave_scaler front-end: parameter defaults,
// divider-control state encoding and the screen-band constants.
package wave_scaler_pkg;

    localparam int IN_W_DEF      = 12;
    localparam int AVG_SHIFT_DEF = 3;
    localparam int WIN_LEN_DEF   = 500;

    // Full screen band and the mid-screen value used for a flat range.
    localparam logic [7:0] FULL_SCALE = 8'd255;
    localparam logic [7:0] MID_SCALE  = 8'd128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_OUT  = 2'd2
    } scale_state_e;

    // Screen rows grow downwards, so a large value must map to a small row.
    function automatic logic [7:0] invert_point(input logic [7:0] level);
        return FULL_SCALE - level;
    endfunction

endpackage

// File: rtl/wave_scaler_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first bit is resolved on the start edge, so the quotient is complete
// NUM_W edges after start and done pulses in the following cycle.
// NUM_W must be at least 2; den must be non-zero when start is raised.
module seq_divider #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_r;
    logic [DEN_W-1:0] den_r;
    logic [NUM_W-1:0] quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;

    logic [DEN_W-1:0] step_rem_s;
    logic [DEN_W-1:0] step_den_s;
    logic             step_bit_s;
    logic [DEN_W:0]   trial_s;
    logic [DEN_W-1:0] rem_next_s;
    logic             q_bit_s;

    // One restoring step: shift in the next numerator bit and try to subtract.
    always_comb begin
        step_rem_s = rem_r;
        step_den_s = den_r;
        step_bit_s = quo_r[NUM_W-1];
        if (start) begin
            step_rem_s = {DEN_W{1'b0}};
            step_den_s = den;
            step_bit_s = num[NUM_W-1];
        end else begin
            step_rem_s = rem_r;
            step_den_s = den_r;
            step_bit_s = quo_r[NUM_W-1];
        end
        trial_s = {step_rem_s, step_bit_s};
        if (trial_s >= {1'b0, step_den_s}) begin
            // Remainder stays below den, so the low bits hold the exact difference.
            rem_next_s = trial_s[DEN_W-1:0] - step_den_s;
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = trial_s[DEN_W-1:0];
            q_bit_s    = 1'b0;
        end
    end

    // Iteration registers: numerator shifts out at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= {DEN_W{1'b0}};
            den_r  <= {DEN_W{1'b0}};
            quo_r  <= {NUM_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= rem_next_s;
            den_r  <= den;
            quo_r  <= {num[NUM_W-2:0], q_bit_s};
            cnt_r  <= CNT_W'(NUM_W - 1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= rem_next_s;
            quo_r <= {quo_r[NUM_W-2:0], q_bit_s};
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign quo  = quo_r;

endmodule

// File: rtl/wave_scaler.sv
// Display front-end: block-averages raw samples, auto-gains each average
// into 0..255 using the previous window's min/max, inverts for screen rows
// and emits one point with a single-cycle strobe.
module wave_scaler
    import wave_scaler_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int AVG_SHIFT = AVG_SHIFT_DEF,
    parameter int WIN_LEN   = WIN_LEN_DEF
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [IN_W-1:0] sample_data,
    input  logic            sample_valid,
    input  logic            stop,
    output logic [7:0]      wave_data,
    output logic            wave_flag,
    output logic            overrun
);

    localparam int ACC_W  = IN_W + AVG_SHIFT;
    localparam int NUM_W  = IN_W + 8;
    localparam int WCNT_W = $clog2(WIN_LEN + 1);

    // Averaging state
    logic [ACC_W-1:0]     acc_r;
    logic [AVG_SHIFT-1:0] scnt_r;
    logic [IN_W-1:0]      avg_r;
    logic                 avg_valid_r;
    logic [ACC_W-1:0]     acc_sum_s;
    logic                 sample_take_s;
    logic                 block_done_s;

    // Range state
    logic [IN_W-1:0]   lo_r;
    logic [IN_W-1:0]   hi_r;
    logic [IN_W-1:0]   tmin_r;
    logic [IN_W-1:0]   tmax_r;
    logic [WCNT_W-1:0] wcnt_r;
    logic [IN_W-1:0]   avg_min_s;
    logic [IN_W-1:0]   avg_max_s;
    logic              win_last_s;

    // Scaling datapath
    logic [IN_W-1:0]  clamp_s;
    logic [IN_W-1:0]  span_s;
    logic [NUM_W-1:0] num_s;
    logic [IN_W-1:0]  den_s;
    logic [NUM_W-1:0] quo_s;
    logic [7:0]       q_sat_s;
    logic             div_start_s;
    logic             div_busy_s;
    logic             div_done_s;

    // Control and registered outputs
    scale_state_e state_r;
    scale_state_e state_next_s;
    logic [7:0]   wave_data_r;
    logic [7:0]   data_next_s;
    logic         wave_flag_r;
    logic         flag_next_s;
    logic         overrun_r;
    logic         idle_s;
    logic         accept_s;
    logic         drop_s;

    assign sample_take_s = sample_valid && !stop;
    assign acc_sum_s     = acc_r + ACC_W'(sample_data);
    assign block_done_s  = sample_take_s && (scnt_r == {AVG_SHIFT{1'b1}});

    // Block accumulator: the last sample of a block publishes the average and restarts the sum.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            acc_r       <= {ACC_W{1'b0}};
            scnt_r      <= {AVG_SHIFT{1'b0}};
            avg_r       <= {IN_W{1'b0}};
            avg_valid_r <= 1'b0;
        end else begin
            avg_valid_r <= block_done_s;
            if (block_done_s) begin
                avg_r  <= acc_sum_s[ACC_W-1:AVG_SHIFT];
                acc_r  <= {ACC_W{1'b0}};
                scnt_r <= {AVG_SHIFT{1'b0}};
            end else if (sample_take_s) begin
                acc_r  <= acc_sum_s;
                scnt_r <= scnt_r + AVG_SHIFT'(1);
            end else begin
                acc_r  <= acc_r;
                scnt_r <= scnt_r;
            end
        end
    end

    // An average is only taken when the scaler is fully idle; anything else is a drop.
    assign idle_s   = (state_r == ST_IDLE) && !div_busy_s;
    assign accept_s = avg_valid_r && idle_s;
    assign drop_s   = avg_valid_r && !idle_s;

    // Clamp the average into the latched range and form the divider operands.
    always_comb begin
        clamp_s = avg_r;
        if (avg_r < lo_r) begin
            clamp_s = lo_r;
        end else if (avg_r > hi_r) begin
            clamp_s = hi_r;
        end else begin
            clamp_s = avg_r;
        end
        span_s = clamp_s - lo_r;
        // span * 255 computed as span * 256 - span.
        num_s  = {span_s, 8'h00} - NUM_W'(span_s);
        den_s  = hi_r - lo_r;
    end

    // Quotient saturates at full scale before inversion.
    always_comb begin
        q_sat_s = quo_s[7:0];
        if (quo_s > NUM_W'(255)) begin
            q_sat_s = FULL_SCALE;
        end else begin
            q_sat_s = quo_s[7:0];
        end
    end

    seq_divider #(
        .NUM_W(NUM_W),
        .DEN_W(IN_W)
    ) u_div (
        .clk  (Clk),
        .rst  (Rst),
        .start(div_start_s),
        .num  (num_s),
        .den  (den_s),
        .busy (div_busy_s),
        .done (div_done_s),
        .quo  (quo_s)
    );

    // Window trackers: accepted averages feed min/max; the last one of a window latches the new range.
    always_comb begin
        avg_min_s = tmin_r;
        avg_max_s = tmax_r;
        if (avg_r < tmin_r) begin
            avg_min_s = avg_r;
        end else begin
            avg_min_s = tmin_r;
        end
        if (avg_r > tmax_r) begin
            avg_max_s = avg_r;
        end else begin
            avg_max_s = tmax_r;
        end
    end

    assign win_last_s = (wcnt_r == WCNT_W'(WIN_LEN - 1));

    // Range registers update after the operands of the completing average were formed from the old range.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            lo_r   <= {IN_W{1'b0}};
            hi_r   <= {IN_W{1'b1}};
            tmin_r <= {IN_W{1'b1}};
            tmax_r <= {IN_W{1'b0}};
            wcnt_r <= {WCNT_W{1'b0}};
        end else if (accept_s) begin
            if (win_last_s) begin
                lo_r   <= avg_min_s;
                hi_r   <= avg_max_s;
                tmin_r <= {IN_W{1'b1}};
                tmax_r <= {IN_W{1'b0}};
                wcnt_r <= {WCNT_W{1'b0}};
            end else begin
                tmin_r <= avg_min_s;
                tmax_r <= avg_max_s;
                wcnt_r <= wcnt_r + WCNT_W'(1);
            end
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Scaler control: next state, divider start and the next output point.
    always_comb begin
        state_next_s = state_r;
        data_next_s  = wave_data_r;
        flag_next_s  = 1'b0;
        div_start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (den_s == {IN_W{1'b0}}) begin
                        // Flat range: nothing to divide, draw mid-screen.
                        state_next_s = ST_OUT;
                        flag_next_s  = 1'b1;
                        data_next_s  = MID_SCALE;
                    end else begin
                        div_start_s  = 1'b1;
                        state_next_s = ST_DIV;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (div_done_s) begin
                    state_next_s = ST_OUT;
                    flag_next_s  = 1'b1;
                    data_next_s  = invert_point(q_sat_s);
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            ST_OUT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; the strobe is high exactly during the OUT cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r     <= ST_IDLE;
            wave_data_r <= 8'd0;
            wave_flag_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wave_data_r <= data_next_s;
            wave_flag_r <= flag_next_s;
            overrun_r   <= overrun_r | drop_s;
        end
    end

    assign wave_data = wave_data_r;
    assign wave_flag = wave_flag_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_wave_scaler.sv
// Directed bench for wave_scaler with default parameters.
module tb_wave_scaler;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        stop;
    logic [7:0]  wave_data;
    logic        wave_flag;
    logic        overrun;

    int checks     = 0;
    int failures   = 0;
    int flag_count = 0;

    wave_scaler dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .stop        (stop),
        .wave_data   (wave_data),
        .wave_flag   (wave_flag),
        .overrun     (overrun)
    );

    always #5 Clk = ~Clk;

    // Count every cycle in which the strobe is high.
    always @(posedge Clk) begin
        if (wave_flag) flag_count <= flag_count + 1;
    end

    task automatic apply_reset();
        Rst = 1'b1; sample_valid = 1'b0; stop = 1'b0; sample_data = 12'd0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    task automatic drive_sample(input logic [11:0] v);
        sample_data  = v;
        sample_valid = 1'b1;
        @(posedge Clk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic drive_block(input logic [11:0] v);
        repeat (8) drive_sample(v);
    endtask

    // lat counts cycles with the block-completing sample cycle as 0.
    task automatic wait_flag(output int lat, output logic [7:0] data, output bit seen);
        lat = 1; seen = 1'b0; data = 8'd0;
        while (!seen && lat < 60) begin
            @(posedge Clk); #1;
            lat++;
            if (wave_flag) begin seen = 1'b1; data = wave_data; end
        end
    endtask

    // Run one block and check its point's value and latency.
    task automatic block_check(input string name, input logic [11:0] v,
                               input logic [7:0] exp_data, input int exp_lat);
        int lat; logic [7:0] d; bit seen;
        drive_block(v);
        wait_flag(lat, d, seen);
        checks++;
        if (!seen) begin
            failures++; $display("FAIL %s_timeout: got no wave_flag expected one", name);
        end else begin
            if (d !== exp_data) begin
                failures++; $display("FAIL %s_data: got %0d expected %0d", name, d, exp_data);
            end
            checks++;
            if (lat != exp_lat) begin
                failures++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (wave_data !== 8'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", wave_data); end
        checks++; if (wave_flag !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b expected 0", wave_flag); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_basic();
        // 2048*255/4095 = 127 -> 255-127 = 128
        block_check("basic", 12'd2048, 8'd128, 22);
        @(posedge Clk); #1;
        checks++; if (wave_flag !== 1'b0) begin failures++; $display("FAIL strobe_width: got %b expected 0", wave_flag); end
    endtask

    task automatic test_stop();
        int lat; logic [7:0] d; bit seen;
        repeat (4) drive_sample(12'd2048);
        stop = 1'b1;
        repeat (3) drive_sample(12'd4095);
        stop = 1'b0;
        repeat (4) drive_sample(12'd2048);
        wait_flag(lat, d, seen);
        checks++;
        if (!seen || d !== 8'd128) begin
            failures++; $display("FAIL stop_hold: got seen=%0d data=%0d expected seen=1 data=128", seen, d);
        end
    endtask

    task automatic test_window();
        int lat; logic [7:0] d; bit seen; int expv; int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            drive_block(12'(1000 + i));
            wait_flag(lat, d, seen);
            // Old range 0..4095: e.g. 1000 -> 193, 1499 -> 162.
            expv = 255 - (((1000 + i) * 255) / 4095);
            checks++;
            if (!seen || d !== 8'(expv)) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL ramp_point_%0d: got %0d seen=%0d expected %0d", i, d, seen, expv);
            end
        end
        // New range 1000..1499.
        block_check("win_top", 12'd1499, 8'd0, 22);
        block_check("win_bottom", 12'd1000, 8'd255, 22);
    endtask

    task automatic test_clamp();
        block_check("clamp_high", 12'd3000, 8'd0, 22);
        block_check("clamp_low", 12'd500, 8'd255, 22);
    endtask

    task automatic test_reset_mid_div();
        int fc;
        // Two back-to-back blocks: first in the divider, second dropped.
        repeat (16) drive_sample(12'd2048);
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL pre_reset_overrun: got %b expected 1", overrun); end
        Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midreset_overrun: got %b expected 0", overrun); end
        checks++; if (wave_data !== 8'd0) begin failures++; $display("FAIL midreset_data: got %0d expected 0", wave_data); end
        fc = flag_count;
        repeat (30) @(posedge Clk);
        #1;
        checks++; if (flag_count != fc) begin failures++; $display("FAIL midreset_noflag: got %0d strobes expected 0", flag_count - fc); end
        // Range back to 0..4095, so 2048 is mid-screen rather than clamped to the top.
        block_check("after_reset", 12'd2048, 8'd128, 22);
    endtask

    task automatic test_den_zero();
        int lat; logic [7:0] d; bit seen; int missing;
        apply_reset();
        missing = 0;
        for (int i = 0; i < 500; i++) begin
            drive_block(12'd1200);
            wait_flag(lat, d, seen);
            if (!seen) missing++;
        end
        checks++; if (missing != 0) begin failures++; $display("FAIL flat_fill: got %0d missing points expected 0", missing); end
        // 500th point still scaled with 0..4095: 1200*255/4095 = 74 -> 181.
        checks++; if (d !== 8'd181) begin failures++; $display("FAIL flat_last_old_range: got %0d expected 181", d); end
        block_check("flat_range", 12'd1200, 8'd128, 2);
    endtask

    task automatic test_back_to_back();
        int fc;
        apply_reset();
        fc = flag_count;
        repeat (8) drive_sample(12'd2048);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_first_block_overrun: got %b expected 0", overrun); end
        repeat (40) drive_sample(12'd2048);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        repeat (30) @(posedge Clk);
        #1;
        // Six blocks at one per 8 cycles: blocks 1 and 4 are scaled, the rest dropped.
        checks++; if (flag_count - fc != 2) begin failures++; $display("FAIL b2b_points: got %0d expected 2", flag_count - fc); end
        checks++; if (wave_data !== 8'd128) begin failures++; $display("FAIL b2b_data: got %0d expected 128", wave_data); end
    endtask

    initial begin
        Rst = 1'b1; sample_valid = 1'b0; stop = 1'b0; sample_data = 12'd0;
        test_reset();
        test_basic();
        test_stop();
        test_window();
        test_clamp();
        test_reset_mid_div();
        test_den_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
